// File: rtl/mwc_pkg.sv
// mwc_pkg: shared types, default widths and index-width helper for mem_write_checker
package mwc_pkg;
  localparam int MWC_ADDR_W = 32;
  localparam int MWC_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_t;
  typedef enum logic [1:0] {FC_NONE, FC_BAD_ADDR, FC_BAD_DATA, FC_TIMEOUT} fail_code_t;
  typedef struct packed {
    logic [MWC_ADDR_W-1:0] addr;
    logic [MWC_DATA_W-1:0] data;
  } exp_entry_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mwc_cfg_table.sv
// mwc_cfg_table: expected-store and ignore-address tables with write port, current-entry read and ignore-hit
module mwc_cfg_table
  import mwc_pkg::*;
#(
  parameter int ADDR_W = MWC_ADDR_W,
  parameter int DATA_W = MWC_DATA_W,
  parameter int NUM_EXP = 4,
  parameter int NUM_IGN = 2,
  localparam int IW = idx_w(NUM_EXP > NUM_IGN ? NUM_EXP : NUM_IGN),
  localparam int EW = $clog2(NUM_EXP + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic              sel,
  input  logic [IW-1:0]     idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_vld,
  input  logic [EW-1:0]     rd_idx,
  input  logic [ADDR_W-1:0] probe_addr,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [DATA_W-1:0] cur_data,
  output logic              ign_hit
);
  logic [ADDR_W-1:0] exp_addr_q [NUM_EXP];
  logic [DATA_W-1:0] exp_data_q [NUM_EXP];
  logic [ADDR_W-1:0] ign_addr_q [NUM_IGN];
  logic              ign_vld_q  [NUM_IGN];
  // Index compares instead of direct indexing so out-of-range writes simply match nothing
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        exp_addr_q[i] <= '0;
        exp_data_q[i] <= '0;
      end
      for (int i = 0; i < NUM_IGN; i++) begin
        ign_addr_q[i] <= '0;
        ign_vld_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_EXP; i++)
        if (we && !sel && idx == IW'(i)) begin
          exp_addr_q[i] <= wr_addr;
          exp_data_q[i] <= wr_data;
        end
      for (int i = 0; i < NUM_IGN; i++)
        if (we && sel && idx == IW'(i)) begin
          ign_addr_q[i] <= wr_addr;
          ign_vld_q[i]  <= wr_vld;
        end
    end
  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    ign_hit  = 1'b0;
    for (int i = 0; i < NUM_EXP; i++)
      if (rd_idx == EW'(i)) begin
        cur_addr = exp_addr_q[i];
        cur_data = exp_data_q[i];
      end
    for (int i = 0; i < NUM_IGN; i++)
      ign_hit = ign_hit | (ign_vld_q[i] && ign_addr_q[i] == probe_addr);
  end
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: ordered data-memory store checker with ignore list and watchdog.
// Define MWC_ERRLOG_EN to add fail_addr/fail_data/fail_cycle capture of the failing event.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W = MWC_ADDR_W,
  parameter int DATA_W = MWC_DATA_W,
  parameter int NUM_EXP = 4,
  parameter int NUM_IGN = 2,
  parameter int TIMEOUT = 1000,
  localparam int IW = idx_w(NUM_EXP > NUM_IGN ? NUM_EXP : NUM_IGN),
  localparam int EW = $clog2(NUM_EXP + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_ign_vld,
  input  logic [EW-1:0]     exp_len,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [EW-1:0]     exp_idx,
  output logic [15:0]       wr_count
`ifdef MWC_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [15:0]       fail_cycle
`endif
);
  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);
  state_t            state_q, state_d;
  fail_code_t        code_q, code_d;
  logic [EW-1:0]     idx_q, idx_d, len_q, len_d;
  logic [15:0]       cnt_q, cnt_d, tmr_q, tmr_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              ign_hit, arm;
  mwc_cfg_table #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_EXP(NUM_EXP), .NUM_IGN(NUM_IGN)) u_tbl (
    .clk(clk), .reset_n(reset_n), .we(cfg_we && state_q != ARMED), .sel(cfg_sel), .idx(cfg_idx),
    .wr_addr(cfg_addr), .wr_data(cfg_data), .wr_vld(cfg_ign_vld), .rd_idx(idx_q),
    .probe_addr(dataadr), .cur_addr(cur_addr), .cur_data(cur_data), .ign_hit(ign_hit)
  );
  assign arm = start && state_q != ARMED;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= FC_NONE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    if (arm) begin
      idx_d   = '0;
      cnt_d   = '0;
      tmr_d   = '0;
      len_d   = exp_len;
      state_d = (exp_len != '0 && int'(exp_len) <= NUM_EXP) ? ARMED : FAIL;
      code_d  = (state_d == FAIL) ? FC_BAD_ADDR : FC_NONE;
    end else if (state_q == ARMED) begin
      tmr_d = tmr_q + 16'd1;
      cnt_d = (memwrite && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
      if (memwrite && dataadr == cur_addr && writedata == cur_data) begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == len_q) ? PASS : ARMED;
      end else if (memwrite && dataadr == cur_addr) begin
        state_d = FAIL;
        code_d  = FC_BAD_DATA;
      end else if (memwrite && !ign_hit) begin
        state_d = FAIL;
        code_d  = FC_BAD_ADDR;
      end
      // A completing store in the watchdog cycle has already moved to PASS and wins
      if (TIMEOUT != 0 && state_d == ARMED && tmr_q == TMAX) begin
        state_d = FAIL;
        code_d  = FC_TIMEOUT;
      end
    end
  end
  always_comb begin
    busy      = state_q == ARMED;
    done      = state_q == PASS || state_q == FAIL;
    pass      = state_q == PASS;
    fail_code = code_q;
    exp_idx   = idx_q;
    wr_count  = cnt_q;
  end
`ifdef MWC_ERRLOG_EN
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic [15:0]       fail_cycle_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_cycle_q <= '0;
    end else if (arm) begin
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_cycle_q <= '0;
    end else if (state_q == ARMED && state_d == FAIL) begin
      fail_addr_q  <= (code_d == FC_TIMEOUT) ? '0 : dataadr;
      fail_data_q  <= (code_d == FC_TIMEOUT) ? '0 : writedata;
      fail_cycle_q <= tmr_q;
    end
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign fail_cycle = fail_cycle_q;
`endif
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed self-checking bench for mem_write_checker (TIMEOUT=20)
module tb_mem_write_checker;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_we = 1'b0, cfg_sel = 1'b0, cfg_ign_vld = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0, cfg_data = '0;
  logic [2:0]  exp_len = '0;
  logic        start = 1'b0, memwrite = 1'b0;
  logic [31:0] dataadr = '0, writedata = '0;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [2:0]  exp_idx;
  logic [15:0] wr_count;
`ifdef MWC_ERRLOG_EN
  logic [31:0] fail_addr, fail_data;
  logic [15:0] fail_cycle;
`endif
  int checks = 0;
  int errors = 0;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(4), .NUM_IGN(2), .TIMEOUT(20)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ign_vld(cfg_ign_vld), .exp_len(exp_len),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code), .exp_idx(exp_idx),
    .wr_count(wr_count)
`ifdef MWC_ERRLOG_EN
    , .fail_addr(fail_addr), .fail_data(fail_data), .fail_cycle(fail_cycle)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic status(input string tag, input logic b, input logic d, input logic p,
                        input logic [1:0] c, input logic [2:0] ei, input logic [15:0] wc);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".pass"}, 32'(pass), 32'(p));
    check({tag, ".code"}, 32'(fail_code), 32'(c));
    check({tag, ".exp_idx"}, 32'(exp_idx), 32'(ei));
    check({tag, ".wr_count"}, 32'(wr_count), 32'(wc));
  endtask

  task automatic cfg(input logic sel, input logic [1:0] idx, input logic [31:0] a,
                     input logic [31:0] d, input logic v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_addr = a; cfg_data = d; cfg_ign_vld = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic arm(input logic [2:0] len);
    @(negedge clk);
    exp_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b1; dataadr = a; writedata = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  initial begin
    #1;
    status("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    // ordered store with two tolerated scratch addresses
    cfg(0, 0, 84, 32'h07001111, 0);
    cfg(1, 0, 80, 0, 1);
    cfg(1, 1, 88, 0, 1);
    arm(1);
    status("armed", 1, 0, 0, 0, 0, 0);
    store(80, 32'h1);
    store(88, 32'h2);
    status("ignored", 1, 0, 0, 0, 0, 2);
    store(84, 32'h07001111);
    status("pass1", 0, 1, 1, 0, 1, 3);
    store(76, 32'h5);
    status("terminal", 0, 1, 1, 0, 1, 3);
    // data mismatch on the expected address
    arm(1);
    status("rearm", 1, 0, 0, 0, 0, 0);
    store(84, 32'h07001112);
    status("baddata", 0, 1, 0, 2, 0, 1);
`ifdef MWC_ERRLOG_EN
    check("baddata.fail_data", fail_data, 32'h07001112);
    check("baddata.fail_addr", fail_addr, 32'd84);
`endif
    // unexpected address, verdict one cycle after the store
    arm(1);
    @(negedge clk);
    memwrite = 1'b1; dataadr = 76; writedata = 32'h0;
    check("badaddr.pre_done", 32'(done), 32'd0);
    @(negedge clk);
    memwrite = 1'b0;
    status("badaddr", 0, 1, 0, 1, 0, 1);
    // three-entry sequence; out-of-range ignore write must be dropped
    cfg(0, 0, 4, 1, 0);
    cfg(0, 1, 8, 2, 0);
    cfg(0, 2, 12, 3, 0);
    cfg(1, 2, 8, 0, 1);
    arm(3);
    store(8, 2);
    status("ooo", 0, 1, 0, 1, 0, 1);
    arm(3);
    store(4, 1);
    store(8, 2);
    cfg(0, 2, 12, 99, 0);
    status("seq_mid", 1, 0, 0, 0, 2, 2);
    store(12, 3);
    status("seq_pass", 0, 1, 1, 0, 3, 3);
    // watchdog expiry at cycle 20 after arm
    cfg(0, 0, 84, 32'h07001111, 0);
    arm(1);
    repeat (19) @(negedge clk);
    status("wd_pre", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    status("wd_fire", 0, 1, 0, 3, 0, 0);
    // completing store in the watchdog cycle wins
    arm(1);
    repeat (18) @(negedge clk);
    store(84, 32'h07001111);
    status("wd_race", 0, 1, 1, 0, 1, 1);
    // asynchronous reset mid-check
    arm(1);
    store(80, 32'h0);
    status("pre_rst", 1, 0, 0, 0, 0, 1);
    #2 reset_n = 1'b0;
    #1;
    status("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    arm(0);
    status("len0", 0, 1, 0, 1, 0, 0);
    arm(5);
    status("len5", 0, 1, 0, 1, 0, 0);
    // ignore table was cleared by reset
    arm(1);
    store(80, 32'h0);
    status("ign_cleared", 0, 1, 0, 1, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
